branch_history_predictor: RTL and testbench

//   Parametrised dynamic branch predictor between Fetcher and RS/ROB commit path.
//   - Table of saturating counters indexed by PC; predicts next fetch PC for B-type and JAL.
//   - Trained by resolved branch outcomes from RS.
//   - Registered predict output: one answer per fetch request, one cycle later.

---
 rtl/branch_history_predictor.sv | 127 ++++++++++++
 tb/tb_branch_history_predictor.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_history_predictor.sv
// Dynamic branch predictor: saturating-counter table indexed by PC, registered one-cycle prediction.
// Define BHP_GSHARE_EN to XOR a global history register into the table index (gshare).
module branch_history_predictor #(
  parameter int XLEN     = 32,
  parameter int IDX_W    = 8,
  parameter int CNT_W    = 2,
  parameter int CNT_INIT = 1,
  parameter int GHR_W    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            Fetcher_Ready,
  input  logic [XLEN-1:0] PC,
  input  logic [31:0]     Inst,
  output logic            Predict_Valid,
  output logic            Predict_Taken,
  output logic [XLEN-1:0] Predict_Jump,
  input  logic            Train_Ready,
  input  logic [XLEN-1:0] Train_PC,
  input  logic            Train_Result
);

  localparam int         ENTRIES   = 1 << IDX_W;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {IDLE, RESP} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt_table [ENTRIES];
  logic [IDX_W-1:0] pred_idx, train_idx;
  logic [CNT_W-1:0] train_cnt, train_cnt_next;
  logic [XLEN-1:0]  b_imm, j_imm;
  logic             next_taken;
  logic [XLEN-1:0]  next_jump;

  wire unused_train_pc = &{1'b0, Train_PC[XLEN-1:IDX_W+2], Train_PC[1:0]};

`ifdef BHP_GSHARE_EN
  logic [GHR_W-1:0] ghr;

  // Both indices use the history as it stood before this edge's shift.
  assign pred_idx  = PC[IDX_W+1:2] ^ IDX_W'(ghr);
  assign train_idx = Train_PC[IDX_W+1:2] ^ IDX_W'(ghr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ghr <= '0;
    else if (rdy && Train_Ready)
      ghr <= (ghr << 1) | GHR_W'(Train_Result);
  end
`else
  localparam int unused_ghr_w = GHR_W;

  assign pred_idx  = PC[IDX_W+1:2];
  assign train_idx = Train_PC[IDX_W+1:2];
`endif

  assign b_imm = {{(XLEN-12){Inst[31]}}, Inst[7], Inst[30:25], Inst[11:8], 1'b0};
  assign j_imm = {{(XLEN-20){Inst[31]}}, Inst[19:12], Inst[20], Inst[30:21], 1'b0};

  always_comb begin
    next_taken = 1'b0;
    next_jump  = PC + XLEN'(4);
    case (Inst[6:0])
      OP_BRANCH: begin
        next_taken = cnt_table[pred_idx][CNT_W-1];
        if (next_taken) next_jump = PC + b_imm;
      end
      OP_JAL: begin
        next_taken = 1'b1;
        next_jump  = PC + j_imm;
      end
      default: ;
    endcase
  end

  assign train_cnt = cnt_table[train_idx];

  always_comb begin
    train_cnt_next = train_cnt;
    if (Train_Result && train_cnt != CNT_MAX)
      train_cnt_next = train_cnt + 1'b1;
    else if (!Train_Result && train_cnt != '0)
      train_cnt_next = train_cnt - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++)
        cnt_table[i] <= CNT_W'(CNT_INIT);
    end else if (rdy && Train_Ready) begin
      cnt_table[train_idx] <= train_cnt_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else if (rdy)
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Fetcher_Ready) state_next = RESP;
      RESP:    state_next = Fetcher_Ready ? RESP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign Predict_Valid = (state == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Predict_Taken <= 1'b0;
      Predict_Jump  <= '0;
    end else if (rdy && Fetcher_Ready) begin
      Predict_Taken <= next_taken;
      Predict_Jump  <= next_jump;
    end
  end

endmodule

// File: tb/tb_branch_history_predictor.sv
// Scoreboard bench for branch_history_predictor; expected predictions queued at request time.
module tb_branch_history_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        Fetcher_Ready = 1'b0;
  logic [31:0] PC = '0;
  logic [31:0] Inst = '0;
  logic        Predict_Valid;
  logic        Predict_Taken;
  logic [31:0] Predict_Jump;
  logic        Train_Ready = 1'b0;
  logic [31:0] Train_PC = '0;
  logic        Train_Result = 1'b0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        taken;
    logic [31:0] jump;
    string       name;
  } exp_t;

  exp_t sb[$];

  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] JALR = 32'h000080E7;

  branch_history_predictor dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .Fetcher_Ready(Fetcher_Ready), .PC(PC), .Inst(Inst),
    .Predict_Valid(Predict_Valid), .Predict_Taken(Predict_Taken), .Predict_Jump(Predict_Jump),
    .Train_Ready(Train_Ready), .Train_PC(Train_PC), .Train_Result(Train_Result)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  function automatic logic [31:0] enc_b(input int imm);
    logic [12:0] i;
    i = imm[12:0];
    return {i[12], i[10:5], 10'd0, 3'd0, i[4:1], i[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int imm);
    logic [20:0] i;
    i = imm[20:0];
    return {i[20], i[10:1], i[11], i[19:12], 5'd0, 7'b1101111};
  endfunction

  // Called at a negedge; returns at the negedge after the request was sampled.
  task automatic issue(input logic [31:0] pc, input logic [31:0] inst,
                       input logic t, input logic [31:0] j, input string nm);
    exp_t e;
    Fetcher_Ready = 1'b1; PC = pc; Inst = inst;
    e.taken = t; e.jump = j; e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    Fetcher_Ready = 1'b0;
  endtask

  task automatic train(input logic [31:0] pc, input logic res);
    Train_Ready = 1'b1; Train_PC = pc; Train_Result = res;
    @(negedge clk);
    Train_Ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (Predict_Valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", Predict_Valid); end
    tests++;
    if (Predict_Taken !== 1'b0) begin fails++; $display("FAIL reset_taken: got %b want 0", Predict_Taken); end
    tests++;
    if (Predict_Jump !== 32'h0) begin fails++; $display("FAIL reset_jump: got %h want 0", Predict_Jump); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_untrained();
    exp_t e;
    issue(32'h100, 32'h00000863, 1'b0, 32'h104, "untrained_btype");
    e = sb.pop_front(); tests++;
    if (Predict_Valid !== 1'b1 || Predict_Taken !== e.taken || Predict_Jump !== e.jump) begin
      fails++;
      $display("FAIL %s: got valid=%b taken=%b jump=%h want valid=1 taken=%b jump=%h",
               e.name, Predict_Valid, Predict_Taken, Predict_Jump, e.taken, e.jump);
    end
    @(negedge clk);
  endtask

  task automatic test_jal_back_to_back();
    exp_t e;
    logic [31:0] pcs [5]  = '{32'h200, 32'h204, 32'hFFFFFFFC, 32'h10, 32'h80};
    logic [31:0] ins [5]  = '{32'hFF9FF06F, ADDI, ADDI, enc_j(-32), JALR};
    logic        tk  [5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] jp  [5]  = '{32'h1F8, 32'h208, 32'h0, 32'hFFFFFFF0, 32'h84};
    string       nm  [5]  = '{"jal_neg", "addi_b2b", "addi_wrap", "jal_wrap", "jalr_not_pred"};
    for (int k = 0; k < 5; k++) begin
      issue(pcs[k], ins[k], tk[k], jp[k], nm[k]);
      e = sb.pop_front(); tests++;
      if (Predict_Valid !== 1'b1 || Predict_Taken !== e.taken || Predict_Jump !== e.jump) begin
        fails++;
        $display("FAIL %s: got valid=%b taken=%b jump=%h want valid=1 taken=%b jump=%h",
                 e.name, Predict_Valid, Predict_Taken, Predict_Jump, e.taken, e.jump);
      end
    end
    @(negedge clk);
    tests++;
    if (Predict_Valid !== 1'b0) begin fails++; $display("FAIL valid_drop: got %b want 0", Predict_Valid); end
  endtask

  task automatic test_training();
    exp_t e;
    // {train_pc, result, repeats, predict_pc, imm, taken, jump}
    logic [31:0] tpc [6] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h180, 32'h180};
    logic        res [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    int          rep [6] = '{2, 2, 1, 1, 3, 1};
    int          imm [6] = '{16, 16, 16, 16, -32, -32};
    logic        tk  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] jp  [6] = '{32'h110, 32'h110, 32'h110, 32'h104, 32'h184, 32'h184};
    string       nm  [6] = '{"trained_taken", "saturated_high", "sat_minus_one",
                             "back_not_taken", "saturated_low", "low_plus_one"};
    for (int k = 0; k < 6; k++) begin
      for (int r = 0; r < rep[k]; r++) train(tpc[k], res[k]);
      issue(tpc[k], enc_b(imm[k]), tk[k], jp[k], nm[k]);
      e = sb.pop_front(); tests++;
      if (Predict_Valid !== 1'b1 || Predict_Taken !== e.taken || Predict_Jump !== e.jump) begin
        fails++;
        $display("FAIL %s: got valid=%b taken=%b jump=%h want valid=1 taken=%b jump=%h",
                 e.name, Predict_Valid, Predict_Taken, Predict_Jump, e.taken, e.jump);
      end
    end
    train(32'h180, 1'b1);
    issue(32'h180, enc_b(-32), 1'b1, 32'h160, "low_plus_two");
    e = sb.pop_front(); tests++;
    if (Predict_Valid !== 1'b1 || Predict_Taken !== e.taken || Predict_Jump !== e.jump) begin
      fails++;
      $display("FAIL %s: got valid=%b taken=%b jump=%h want valid=1 taken=%b jump=%h",
               e.name, Predict_Valid, Predict_Taken, Predict_Jump, e.taken, e.jump);
    end
    @(negedge clk);
  endtask

  task automatic test_same_edge();
    exp_t e;
    Train_Ready = 1'b1; Train_PC = 32'h300; Train_Result = 1'b1;
    issue(32'h300, enc_b(8), 1'b0, 32'h304, "same_edge_pre_update");
    Train_Ready = 1'b0;
    e = sb.pop_front(); tests++;
    if (Predict_Valid !== 1'b1 || Predict_Taken !== e.taken || Predict_Jump !== e.jump) begin
      fails++;
      $display("FAIL %s: got valid=%b taken=%b jump=%h want valid=1 taken=%b jump=%h",
               e.name, Predict_Valid, Predict_Taken, Predict_Jump, e.taken, e.jump);
    end
    issue(32'h300, enc_b(8), 1'b1, 32'h308, "same_edge_post_update");
    e = sb.pop_front(); tests++;
    if (Predict_Valid !== 1'b1 || Predict_Taken !== e.taken || Predict_Jump !== e.jump) begin
      fails++;
      $display("FAIL %s: got valid=%b taken=%b jump=%h want valid=1 taken=%b jump=%h",
               e.name, Predict_Valid, Predict_Taken, Predict_Jump, e.taken, e.jump);
    end
    @(negedge clk);
  endtask

  task automatic test_rdy_hold();
    exp_t e;
    issue(32'h400, enc_b(16), 1'b0, 32'h404, "rdy_hold");
    e = sb.pop_front();
    rdy = 1'b0;
    Fetcher_Ready = 1'b1; PC = 32'h800; Inst = enc_j(64);
    Train_Ready = 1'b1; Train_PC = 32'h400; Train_Result = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (Predict_Valid !== 1'b1 || Predict_Taken !== e.taken || Predict_Jump !== e.jump) begin
        fails++;
        $display("FAIL %s[%0d]: got valid=%b taken=%b jump=%h want valid=1 taken=%b jump=%h",
                 e.name, k, Predict_Valid, Predict_Taken, Predict_Jump, e.taken, e.jump);
      end
      if (k < 3) @(negedge clk);
    end
    rdy = 1'b1; Fetcher_Ready = 1'b0; Train_Ready = 1'b0;
    @(negedge clk);
    tests++;
    if (Predict_Valid !== 1'b0) begin fails++; $display("FAIL rdy_release_valid: got %b want 0", Predict_Valid); end
    issue(32'h400, enc_b(16), 1'b0, 32'h404, "rdy_train_ignored");
    e = sb.pop_front(); tests++;
    if (Predict_Valid !== 1'b1 || Predict_Taken !== e.taken || Predict_Jump !== e.jump) begin
      fails++;
      $display("FAIL %s: got valid=%b taken=%b jump=%h want valid=1 taken=%b jump=%h",
               e.name, Predict_Valid, Predict_Taken, Predict_Jump, e.taken, e.jump);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    train(32'h520, 1'b1);
    train(32'h520, 1'b1);
    issue(32'h520, enc_b(16), 1'b1, 32'h530, "pre_reset_taken");
    e = sb.pop_front(); tests++;
    if (Predict_Valid !== 1'b1 || Predict_Taken !== e.taken || Predict_Jump !== e.jump) begin
      fails++;
      $display("FAIL %s: got valid=%b taken=%b jump=%h want valid=1 taken=%b jump=%h",
               e.name, Predict_Valid, Predict_Taken, Predict_Jump, e.taken, e.jump);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (Predict_Valid !== 1'b0) begin fails++; $display("FAIL midreset_valid: got %b want 0", Predict_Valid); end
    tests++;
    if (Predict_Taken !== 1'b0) begin fails++; $display("FAIL midreset_taken: got %b want 0", Predict_Taken); end
    tests++;
    if (Predict_Jump !== 32'h0) begin fails++; $display("FAIL midreset_jump: got %h want 0", Predict_Jump); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(32'h520, enc_b(16), 1'b0, 32'h524, "post_reset_reinit");
    e = sb.pop_front(); tests++;
    if (Predict_Valid !== 1'b1 || Predict_Taken !== e.taken || Predict_Jump !== e.jump) begin
      fails++;
      $display("FAIL %s: got valid=%b taken=%b jump=%h want valid=1 taken=%b jump=%h",
               e.name, Predict_Valid, Predict_Taken, Predict_Jump, e.taken, e.jump);
    end
    @(negedge clk);
  endtask

  task automatic test_gshare();
    exp_t e;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    // GHR=0: entry 0x40 -> 2, then GHR becomes 1.
    train(32'h100, 1'b1);
    issue(32'h100, enc_b(16), 1'b0, 32'h104, "gshare_new_history");
    e = sb.pop_front(); tests++;
    if (Predict_Valid !== 1'b1 || Predict_Taken !== e.taken || Predict_Jump !== e.jump) begin
      fails++;
      $display("FAIL %s: got valid=%b taken=%b jump=%h want valid=1 taken=%b jump=%h",
               e.name, Predict_Valid, Predict_Taken, Predict_Jump, e.taken, e.jump);
    end
    // PC index 0x41 ^ GHR 0x01 hits the trained entry 0x40.
    issue(32'h104, enc_b(16), 1'b1, 32'h114, "gshare_xor_hit");
    e = sb.pop_front(); tests++;
    if (Predict_Valid !== 1'b1 || Predict_Taken !== e.taken || Predict_Jump !== e.jump) begin
      fails++;
      $display("FAIL %s: got valid=%b taken=%b jump=%h want valid=1 taken=%b jump=%h",
               e.name, Predict_Valid, Predict_Taken, Predict_Jump, e.taken, e.jump);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_untrained();
    test_jal_back_to_back();
    test_rdy_hold();
`ifdef BHP_GSHARE_EN
    test_gshare();
`else
    test_training();
    test_same_edge();
    test_reset_mid();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
